// File: rtl/uart_frame_tx.sv
// Frame serializer in front of the UART TX FIFO: captures a wide frame on a
// start strobe and streams it one character per ready/valid handshake.
// Ports: clk, rst (sync, active-high); i_stb/i_data start a frame; i_abort
// cancels it; o_byte/o_valid/i_ready form the character stream; o_busy,
// o_done (one-cycle pulse) and o_count (characters accepted) report status.
module uart_frame_tx #(
  parameter int         NBYTES    = 625,
  parameter bit         MSB_FIRST = 1'b1,
  parameter bit         HEX_MODE  = 1'b0,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_BYTE = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stb,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_byte,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [15:0]           o_count
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES + 1);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    TERM,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  sh, sh_n;
  logic [IW-1:0] idx, idx_n;
  logic          nib, nib_n;
  logic [15:0]   count_n;
  logic [7:0]    byte_n;
  logic          valid_n;
  logic          done_n;
  logic          xfer;
  logic [7:0]    head_n;
  logic [3:0]    nibble_n;
  logic [7:0]    hex_n;
  logic [7:0]    char_n;

  assign xfer   = o_valid & i_ready;
  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      idx     <= '0;
      nib     <= 1'b0;
      o_count <= '0;
      o_byte  <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      idx     <= idx_n;
      nib     <= nib_n;
      o_count <= count_n;
      o_byte  <= byte_n;
      o_valid <= valid_n;
      o_done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    nib_n   = nib;
    count_n = o_count;
    unique case (state)
      IDLE: begin
        if (i_stb) begin
          sh_n    = i_data;
          idx_n   = '0;
          nib_n   = 1'b0;
          count_n = '0;
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (o_count != 16'hFFFF) count_n = o_count + 16'd1;
          // in hex mode the byte only advances after its low nibble
          if (HEX_MODE && !nib) begin
            nib_n = 1'b1;
          end else begin
            nib_n = 1'b0;
            sh_n  = MSB_FIRST ? (sh << 8) : (sh >> 8);
            idx_n = idx + 1'b1;
            if (idx == LAST) state_n = TERM_EN ? TERM : DONE;
          end
        end
        if (i_abort) state_n = IDLE;
      end
      TERM: begin
        if (xfer) begin
          if (o_count != 16'hFFFF) count_n = o_count + 16'd1;
          state_n = DONE;
        end
        if (i_abort) state_n = IDLE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so the character on
  // o_byte always matches the state it is presented in.
  always_comb begin
    head_n   = MSB_FIRST ? sh_n[W-1 -: 8] : sh_n[7:0];
    nibble_n = nib_n ? head_n[3:0] : head_n[7:4];
    if (nibble_n < 4'd10) hex_n = 8'h30 + {4'h0, nibble_n};
    else                  hex_n = 8'h37 + {4'h0, nibble_n};
    if (state_n == TERM) char_n = TERM_BYTE;
    else if (HEX_MODE)   char_n = hex_n;
    else                 char_n = head_n;
    valid_n = (state_n == PAYLOAD) || (state_n == TERM);
    byte_n  = valid_n ? char_n : o_byte;
    done_n  = (state_n == DONE);
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed-vector bench for uart_frame_tx over four parameter sets.
// A: 4B msb/raw/term  B: 4B lsb/raw/term  C: 2B hex/no-term  D: 1B hex/term
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] dat = '0;
  int          sel = 0;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
  logic        busy_c, done_c, valid_c, busy_d, done_d, valid_d;
  logic [7:0]  byte_a, byte_b, byte_c, byte_d;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic        stb_a, stb_b, stb_c, stb_d;

  assign stb_a = stb && (sel == 0);
  assign stb_b = stb && (sel == 1);
  assign stb_c = stb && (sel == 2);
  assign stb_d = stb && (sel == 3);

  uart_frame_tx #(.NBYTES(4), .MSB_FIRST(1'b1), .HEX_MODE(1'b0),
    .TERM_EN(1'b1), .TERM_BYTE(8'h0D)) u_a (
    .clk(clk), .rst(rst), .i_stb(stb_a), .i_data(dat), .i_abort(abort),
    .o_busy(busy_a), .o_done(done_a), .o_byte(byte_a), .o_valid(valid_a),
    .i_ready(ready), .o_count(cnt_a));

  uart_frame_tx #(.NBYTES(4), .MSB_FIRST(1'b0), .HEX_MODE(1'b0),
    .TERM_EN(1'b1), .TERM_BYTE(8'h0D)) u_b (
    .clk(clk), .rst(rst), .i_stb(stb_b), .i_data(dat), .i_abort(abort),
    .o_busy(busy_b), .o_done(done_b), .o_byte(byte_b), .o_valid(valid_b),
    .i_ready(ready), .o_count(cnt_b));

  uart_frame_tx #(.NBYTES(2), .MSB_FIRST(1'b1), .HEX_MODE(1'b1),
    .TERM_EN(1'b0), .TERM_BYTE(8'h0D)) u_c (
    .clk(clk), .rst(rst), .i_stb(stb_c), .i_data(dat[15:0]), .i_abort(abort),
    .o_busy(busy_c), .o_done(done_c), .o_byte(byte_c), .o_valid(valid_c),
    .i_ready(ready), .o_count(cnt_c));

  uart_frame_tx #(.NBYTES(1), .MSB_FIRST(1'b1), .HEX_MODE(1'b1),
    .TERM_EN(1'b1), .TERM_BYTE(8'h0D)) u_d (
    .clk(clk), .rst(rst), .i_stb(stb_d), .i_data(dat[7:0]), .i_abort(abort),
    .o_busy(busy_d), .o_done(done_d), .o_byte(byte_d), .o_valid(valid_d),
    .i_ready(ready), .o_count(cnt_d));

  logic        busy, done, valid;
  logic [7:0]  obyte;
  logic [15:0] cnt;

  always_comb begin
    busy = busy_a; done = done_a; valid = valid_a;
    obyte = byte_a; cnt = cnt_a;
    case (sel)
      1: begin
        busy = busy_b; done = done_b; valid = valid_b;
        obyte = byte_b; cnt = cnt_b;
      end
      2: begin
        busy = busy_c; done = done_c; valid = valid_c;
        obyte = byte_c; cnt = cnt_c;
      end
      3: begin
        busy = busy_d; done = done_d; valid = valid_d;
        obyte = byte_d; cnt = cnt_d;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int s, input logic [31:0] d);
    sel = s;
    dat = d;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  // Runs one frame, stalling `slen` cycles while character `sat` is shown.
  task automatic run_frame(input string nm, input int s,
                           input logic [31:0] d, input int n,
                           input logic [7:0] exp [5],
                           input int sat, input int slen);
    int got = 0;
    int stl = 0;
    int cyc = 0;
    start(s, d);
    while (got < n) begin
      if (cyc > 40) begin
        errs++;
        $display("FAIL %s timeout got=%0d want=%0d chars", nm, got, n);
        break;
      end
      vecs++;
      if (valid !== 1'b1 || obyte !== exp[got] || cnt !== 16'(got)
          || done !== 1'b0) begin
        errs++;
        $display("FAIL %s char%0d valid=%b byte=%h cnt=%0d done=%b want 1 %h %0d 0",
                 nm, got, valid, obyte, cnt, done, exp[got], got);
      end
      if (got == sat && stl < slen) begin
        ready = 1'b0;
        stl++;
      end else begin
        ready = 1'b1;
        got++;
      end
      tick();
      cyc++;
    end
    ready = 1'b1;
    vecs++;
    if (done !== 1'b1 || valid !== 1'b0 || cnt !== 16'(n)
        || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s end done=%b valid=%b cnt=%0d busy=%b want 1 0 %0d 1",
               nm, done, valid, cnt, busy, n);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt !== 16'(n)) begin
      errs++;
      $display("FAIL %s idle done=%b busy=%b cnt=%0d want 0 0 %0d",
               nm, done, busy, cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      vecs++;
      if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0
          || obyte !== 8'h00 || cnt !== 16'h0) begin
        errs++;
        $display("FAIL reset dut%0d b=%b d=%b v=%b byte=%h cnt=%0d want all 0",
                 k, busy, done, valid, obyte, cnt);
      end
    end
    tick();
  endtask

  task automatic test_msb_first();
    run_frame("msb_first", 0, 32'hDEADBEEF, 5,
              '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0D}, -1, 0);
  endtask

  task automatic test_lsb_stall();
    run_frame("lsb_stall", 1, 32'hDEADBEEF, 5,
              '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D}, 1, 3);
  endtask

  task automatic test_hex();
    run_frame("hex2", 2, 32'h00003A0F, 4,
              '{8'h33, 8'h41, 8'h30, 8'h46, 8'h00}, -1, 0);
    run_frame("hex1_term", 3, 32'h000000A5, 3,
              '{8'h41, 8'h35, 8'h0D, 8'h00, 8'h00}, 2, 2);
  endtask

  task automatic test_abort();
    start(0, 32'hDEADBEEF);
    tick();
    tick();
    vecs++;
    if (obyte !== 8'hBE || cnt !== 16'd2) begin
      errs++;
      $display("FAIL abort_pre byte=%h cnt=%0d want BE 2", obyte, cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vecs++;
    if (valid !== 1'b0 || cnt !== 16'd3 || done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort v=%b cnt=%0d done=%b busy=%b want 0 3 0 0",
               valid, cnt, done, busy);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || valid !== 1'b0 || cnt !== 16'd3) begin
      errs++;
      $display("FAIL abort_after done=%b v=%b cnt=%0d want 0 0 3",
               done, valid, cnt);
    end
    run_frame("abort_fresh", 0, 32'hDEADBEEF, 5,
              '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0D}, -1, 0);
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp [5];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0D};
    start(0, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        dat = 32'h11223344;
        stb = 1'b1;
      end else begin
        stb = 1'b0;
      end
      vecs++;
      if (valid !== 1'b1 || obyte !== exp[i]) begin
        errs++;
        $display("FAIL busy_ign char%0d v=%b byte=%h want 1 %h",
                 i, valid, obyte, exp[i]);
      end
      tick();
    end
    stb = 1'b0;
    vecs++;
    if (done !== 1'b1 || cnt !== 16'd5) begin
      errs++;
      $display("FAIL busy_ign done=%b cnt=%0d want 1 5", done, cnt);
    end
    dat = 32'h11223344;
    stb = 1'b1;
    tick();
    stb = 1'b0;
    vecs++;
    if (busy !== 1'b0 || valid !== 1'b0 || cnt !== 16'd5) begin
      errs++;
      $display("FAIL done_ign busy=%b v=%b cnt=%0d want 0 0 5",
               busy, valid, cnt);
    end
  endtask

  task automatic test_mid_reset();
    start(0, 32'hDEADBEEF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0
        || obyte !== 8'h00 || cnt !== 16'h0) begin
      errs++;
      $display("FAIL mid_rst b=%b d=%b v=%b byte=%h cnt=%0d want all 0",
               busy, done, valid, obyte, cnt);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst_after done=%b v=%b want 0 0", done, valid);
    end
    run_frame("rst_fresh", 0, 32'h11223344, 5,
              '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0D}, -1, 0);
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_stall();
    test_hex();
    test_abort();
    test_busy_ignore();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised frame serializer that sits in front of the UART transmit FIFO. It captures a wide frame on a start strobe and streams it out one character per handshake over a ready/valid byte interface. Over the fixed 625-byte sender it adds:
- configurable frame length
- selectable byte order
- optional ASCII-hex encoding
- optional terminator character
- abort input
- done pulse and progress count

Parameters:
NBYTES, 625, payload bytes per frame (1..4095)
MSB_FIRST, 1, 1: byte i_data[8*NBYTES-1 -: 8] sent first; 0: i_data[7:0] sent first
HEX_MODE, 0, 1: each payload byte sent as two uppercase ASCII hex chars, high nibble first; 0: raw byte
TERM_EN, 1, 1: append TERM_BYTE after payload
TERM_BYTE, 8'h0D, terminator character

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_stb  in  1  start request; sampled only in IDLE
i_data  in  8*NBYTES  frame payload, captured on accepted i_stb
i_abort  in  1  cancel frame in progress
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse after final character accepted
o_byte  out  8  current character
o_valid  out  1  o_byte valid
i_ready  in  1  sink (FIFO not full) accepts o_byte when o_valid & i_ready
o_count  out  16  characters accepted in current frame

Behaviour:
- Reset: state IDLE; o_valid=0, o_busy=0, o_done=0, o_byte=0, o_count=0; shift register cleared. Reset mid-frame: o_valid drops at next edge, nothing further sent, no o_done.
- Total characters per frame: N = NBYTES*(HEX_MODE?2:1) + TERM_EN.
- States: IDLE, PAYLOAD, TERM, DONE.
- IDLE:
  - On i_stb: capture i_data into shift register, clear o_count, enter PAYLOAD.
  - First character is registered onto o_byte with o_valid=1 in the cycle after i_stb (latency 1).
- Handshake (stream rules):
  - o_byte and o_valid are registered outputs.
  - While o_valid & ~i_ready, o_byte is held stable.
  - On a transfer (o_valid & i_ready), o_count increments and the next character is presented on the following cycle with o_valid still high. Throughput is 1 char/cycle with no bubbles.
- PAYLOAD, HEX_MODE=0:
  - Each transfer shifts the register by 8 bits, toward the MSB when MSB_FIRST=1, otherwise toward the LSB.
  - After NBYTES transfers: go to TERM if TERM_EN=1, else DONE.
- PAYLOAD, HEX_MODE=1:
  - A nibble toggle selects the high nibble, then the low nibble; the shift occurs only after the low-nibble transfer.
  - Encoding: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10).
- TERM: present TERM_BYTE; on transfer go to DONE.
- DONE:
  - o_valid=0, o_done=1 for exactly one cycle, then IDLE.
  - o_count holds N until the next start.
  - i_stb during DONE is ignored.
- Busy rules:
  - i_stb while o_busy=1 is ignored; the captured frame is unchanged.
  - o_busy deasserts on the same edge o_done falls.
- Abort:
  - i_abort in PAYLOAD or TERM: next state IDLE, o_valid=0 at next edge, no o_done, o_count holds its value.
  - If a transfer coincides with i_abort, that character counts as sent (o_count increments), then abort.
  - i_abort in IDLE or DONE has no effect; i_stb together with i_abort in IDLE starts a frame.
- Counters: payload byte index is ceil(log2(NBYTES+1)) bits, no wrap within a frame. o_count saturates at 16'hFFFF.
- NBYTES=1 must work: one payload character (two in HEX_MODE), then terminator.

Test Plan:
1. NBYTES=4, MSB_FIRST=1, HEX=0, TERM_EN=1, i_ready=1, i_data=32'hDEADBEEF, pulse i_stb -> cycles 1..5 o_byte = DE,AD,BE,EF,0D with o_valid=1; o_done pulse at cycle 6; o_count=5.
2. Same config with MSB_FIRST=0 and i_ready low for 3 cycles after the second character -> sequence EF,BE,AD,DE,0D; o_byte=BE held stable through the stall; no character lost or duplicated.
3. HEX_MODE=1, NBYTES=2, i_data=16'h3A0F, TERM_EN=0 -> chars '3','A','0','F' (33,41,30,46); o_done after the 4th; o_count=4.
4. i_abort asserted with i_ready=1 during the 3rd character in config 1 -> o_count=3, o_valid=0 next cycle, no o_done; a new i_stb then sends the full fresh frame.
5. i_stb with i_data=32'h11223344 while busy with config 1 frame -> ignored; original frame output unchanged.
6. rst asserted mid-frame -> all outputs 0 next cycle; IDLE; the next i_stb frame is correct.
